// File: rtl/adder_chk_pkg.sv
// Shared types and default sizes for the adder response checker.
// exp_entry_t is fixed at CHK_WIDTH; resize the checker by changing CHK_WIDTH here.
package adder_chk_pkg;

    localparam int CHK_WIDTH = 3;
    localparam int CHK_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [CHK_WIDTH-1:0] a;
        logic [CHK_WIDTH-1:0] b;
        logic [CHK_WIDTH-1:0] exp;
    } exp_entry_t;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO of expected-value entries; head is the oldest entry, shown combinationally.
// Pointers carry an extra wrap bit so full and empty are distinguishable; clr flushes in one cycle.
module chk_fifo
    import adder_chk_pkg::*;
#(
    parameter int DEPTH = CHK_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  exp_entry_t din,
    output exp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    exp_entry_t  mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop && !empty)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clr)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/adder_resp_checker.sv
// Queues a+b for every accepted operand pair and checks it against later adder results.
// Counts, stickies and first-mismatch record update one cycle after res_valid; verdict on done.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = CHK_WIDTH,
    parameter int DEPTH = CHK_DEPTH,
    parameter int CNT_W = 16,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_c,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             orphan,
    output logic             timeout,
    output logic             mism_valid,
    output logic [WIDTH-1:0] mism_a,
    output logic [WIDTH-1:0] mism_b,
    output logic [WIDTH-1:0] mism_exp,
    output logic [WIDTH-1:0] mism_got,
    output logic             done,
    output logic             pass
);

    localparam int TW = $clog2(TMO + 1);

    state_t     state_q;
    state_t     state_d;
    exp_entry_t wr_ent;
    exp_entry_t head;
    logic       full;
    logic       empty;
    logic       running;
    logic       push;
    logic       pop;
    logic       orphan_hit;
    logic       tmo_hit;
    logic [TW-1:0] idle_q;
    logic [TW-1:0] idle_nxt;

    // start takes priority over every other action in its cycle, including pushes and pops.
    always_comb begin
        running    = (state_q == RUN) || (state_q == DRAIN);
        op_ready   = (state_q == RUN) && !full;
        push       = op_valid && op_ready && !start;
        pop        = res_valid && running && !empty && !start;
        orphan_hit = res_valid && running && empty && !start;
        idle_nxt   = pop ? '0 : idle_q + TW'(1);
        tmo_hit    = (state_q == DRAIN) && !empty && (idle_nxt == TW'(TMO));
        wr_ent.a   = op_a;
        wr_ent.b   = op_b;
        wr_ent.exp = op_a + op_b;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = empty ? DONE : DRAIN;
            DRAIN:   if (empty || tmo_hit) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (start)
            state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    chk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   (wr_ent),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            orphan     <= 1'b0;
            timeout    <= 1'b0;
            mism_valid <= 1'b0;
            mism_a     <= '0;
            mism_b     <= '0;
            mism_exp   <= '0;
            mism_got   <= '0;
            idle_q     <= '0;
        end else if (start) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            orphan     <= 1'b0;
            timeout    <= 1'b0;
            mism_valid <= 1'b0;
            mism_a     <= '0;
            mism_b     <= '0;
            mism_exp   <= '0;
            mism_got   <= '0;
            idle_q     <= '0;
        end else begin
            if (pop) begin
                if (head.exp == res_c) begin
                    if (pass_cnt != '1)
                        pass_cnt <= pass_cnt + CNT_W'(1);
                end else begin
                    if (fail_cnt != '1)
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    if (!mism_valid) begin
                        mism_valid <= 1'b1;
                        mism_a     <= head.a;
                        mism_b     <= head.b;
                        mism_exp   <= head.exp;
                        mism_got   <= res_c;
                    end
                end
            end
            if (orphan_hit)
                orphan <= 1'b1;
            if (tmo_hit)
                timeout <= 1'b1;
            idle_q <= (state_q == DRAIN) ? idle_nxt : '0;
        end
    end

    assign done = (state_q == DONE);
    assign pass = done && (fail_cnt == '0) && !orphan && !timeout;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Scoreboard bench: a queue-based model predicts checker status per result; a monitor compares.
module tb_adder_resp_checker;

    localparam int W   = 3;
    localparam int CW  = 16;
    localparam int TMO = 15;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          res_valid = 1'b0;
    logic [W-1:0]  res_c = '0;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          orphan;
    logic          timeout;
    logic          mism_valid;
    logic [W-1:0]  mism_a;
    logic [W-1:0]  mism_b;
    logic [W-1:0]  mism_exp;
    logic [W-1:0]  mism_got;
    logic          done;
    logic          pass;

    adder_resp_checker #(.WIDTH(W), .DEPTH(DEP), .CNT_W(CW), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_c      (res_c),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .orphan     (orphan),
        .timeout    (timeout),
        .mism_valid (mism_valid),
        .mism_a     (mism_a),
        .mism_b     (mism_b),
        .mism_exp   (mism_exp),
        .mism_got   (mism_got),
        .done       (done),
        .pass       (pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
    } pair_t;

    typedef struct packed {
        logic [CW-1:0] p;
        logic [CW-1:0] f;
        logic          o;
        logic          mv;
        logic [W-1:0]  ma;
        logic [W-1:0]  mb;
        logic [W-1:0]  me;
        logic [W-1:0]  mg;
    } snap_t;

    int    checks = 0;
    int    failures = 0;

    // Reference model: state 0 idle, 1 run, 2 drain, 3 done.
    int    m_st = 0;
    int    m_pass, m_fail;
    bit    m_orph, m_mv;
    int    m_ma, m_mb, m_me, m_mg;
    pair_t mq[$];
    snap_t sbq[$];
    snap_t mon_s;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int head_sum();
        return (mq[0].a + mq[0].b) % (1 << W);
    endfunction

    // Inputs are applied #1 after a rising edge and held for one full cycle.
    task automatic step(input bit ov, input int a, input int b, input bit rv, input int c);
        bit    rdy_exp;
        pair_t p;
        int    e;
        snap_t s;
        op_valid  = ov;
        op_a      = W'(a);
        op_b      = W'(b);
        res_valid = rv;
        res_c     = W'(c);
        rdy_exp   = (m_st == 1) && (mq.size() < DEP);
        chk("op_ready", 64'(op_ready), 64'(rdy_exp));
        if (rv && (m_st == 1 || m_st == 2)) begin
            if (mq.size() > 0) begin
                p = mq.pop_front();
                e = (p.a + p.b) % (1 << W);
                if (e == c) m_pass++;
                else begin
                    m_fail++;
                    if (!m_mv) begin
                        m_mv = 1; m_ma = p.a; m_mb = p.b; m_me = e; m_mg = c;
                    end
                end
            end else begin
                m_orph = 1;
            end
            s.p = CW'(m_pass); s.f = CW'(m_fail); s.o = m_orph; s.mv = m_mv;
            s.ma = W'(m_ma); s.mb = W'(m_mb); s.me = W'(m_me); s.mg = W'(m_mg);
            sbq.push_back(s);
        end
        if (ov && rdy_exp) begin
            p.a = a; p.b = b;
            mq.push_back(p);
        end
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_st = 1; m_pass = 0; m_fail = 0; m_orph = 0; m_mv = 0;
        m_ma = 0; m_mb = 0; m_me = 0; m_mg = 0;
        mq.delete();
        chk("start_clear", {pass_cnt, fail_cnt, orphan, timeout, mism_valid, done}, 64'd0);
    endtask

    task automatic do_stop(input string name);
        bit to_exp;
        int n;
        int n_exp;
        to_exp = (mq.size() != 0);
        n_exp  = to_exp ? TMO : 0;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        m_st = 2;
        n = 0;
        while (!done && n < TMO + 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_st = 3;
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_drain_cycles"}, 64'(n), 64'(n_exp));
        chk({name, "_timeout"}, 64'(timeout), 64'(to_exp));
        chk({name, "_pass"}, 64'(pass), 64'(m_fail == 0 && !m_orph && !to_exp));
    endtask

    // Monitor: each accepted result must be reflected in the status outputs one cycle later.
    initial begin
        forever begin
            @(posedge clk);
            if (res_valid === 1'b1 && sbq.size() > 0) begin
                mon_s = sbq.pop_front();
                @(negedge clk);
                chk("status", {pass_cnt, fail_cnt, orphan, mism_valid, mism_a, mism_b, mism_exp, mism_got},
                    64'(mon_s));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {op_ready, pass_cnt, fail_cnt, orphan, timeout, mism_valid, done, pass}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 1, 1, 0, 0);

        do_start();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 2);
        do_stop("basic");

        do_start();
        step(1, 3, 2, 0, 0);
        step(0, 0, 0, 1, 4);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 3);
        chk("mism_keep", {mism_a, mism_b, mism_exp, mism_got}, {3'd3, 3'd2, 3'd5, 3'd4});
        do_stop("mism");

        do_start();
        step(1, 7, 1, 0, 0);
        step(1, 6, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        do_stop("wrap");

        do_start();
        for (int i = 0; i < 5; i++) step(1, i, i + 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, (2 * i + 1) % 8);
        step(1, 2, 2, 0, 0);
        step(0, 0, 0, 1, 4);
        do_stop("full");

        do_start();
        step(1, 2, 3, 1, 5);
        step(0, 0, 0, 1, 5);
        do_stop("orphan");

        do_start();
        step(1, 4, 4, 0, 0);
        do_stop("tmo");

        do_start();
        for (int i = 0; i < 200; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) c = head_sum();
            else c = $urandom_range(0, 7);
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 2) == 0, c);
        end
        while (mq.size() > 0) step(0, 0, 0, 1, head_sum());
        do_stop("random");

        do_start();
        for (int i = 0; i < 120; i++) begin
            c = (mq.size() > 0) ? head_sum() : 0;
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                 mq.size() > 0 && $urandom_range(0, 1) == 1, c);
        end
        while (mq.size() > 0) step(0, 0, 0, 1, head_sum());
        do_stop("random_clean");

        do_start();
        step(1, 1, 2, 0, 0);
        step(1, 3, 3, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {op_ready, pass_cnt, fail_cnt, orphan, timeout, mism_valid,
                            mism_a, mism_b, mism_exp, mism_got, done, pass}, 64'd0);
        m_st = 0;
        mq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 5, 5, 0, 0);
        do_start();
        step(1, 5, 1, 0, 0);
        step(0, 0, 0, 1, 6);
        chk("post_reset_pass_cnt", 64'(pass_cnt), 64'd1);
        do_stop("post_reset");

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
